ms5803_prom_loader: RTL and testbench

//  Command sequencer directly upstream of the 16-bit I2C PROM controller. On start, waits a

---
 rtl/ms5803_pkg.sv | 27 ++
 rtl/ms5803_prom_loader.sv | 156 +++++++++++++++
 tb/tb_ms5803_prom_loader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ms5803_pkg.sv
// Shared MS5803 definitions: command bytes, PROM geometry and loader states.
// Also used by the conversion sequencer that sits next to the PROM loader.
package ms5803_pkg;

    localparam logic [7:0] PROM_BASE   = 8'hA0;
    localparam int         PROM_WORDS  = 8;
    localparam logic [7:0] CMD_RESET   = 8'h1E;
    localparam logic [7:0] CMD_CONV_D1 = 8'h48;
    localparam logic [7:0] CMD_CONV_D2 = 8'h58;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_PWRUP = 3'd1;
    localparam state_t ST_ISSUE = 3'd2;
    localparam state_t ST_WAIT  = 3'd3;
    localparam state_t ST_STORE = 3'd4;
    localparam state_t ST_CHECK = 3'd5;
    localparam state_t ST_DONE  = 3'd6;
    localparam state_t ST_ERR   = 3'd7;

    // Erased or unconnected PROM cells read back as all-zeros or all-ones.
    function automatic logic bad_word(input logic [15:0] w);
        return (w == 16'h0000) || (w == 16'hFFFF);
    endfunction

endpackage

// File: rtl/ms5803_prom_loader.sv
// Reads the eight MS5803 PROM words through the I2C PROM controller
// into a local register file and flags an implausible image.
module ms5803_prom_loader #(
    parameter int unsigned PWRUP_CYC   = 200_000,
    parameter int unsigned TIMEOUT_CYC = 2_000_000,
    parameter logic [7:0]  PROM_BASE   = ms5803_pkg::PROM_BASE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  coef_idx,
    output logic [15:0] coef,
    output logic        busy,
    output logic        done,
    output logic        prom_err,
    output logic [7:0]  i2c_addr,
    output logic [7:0]  i2c_wdata,
    output logic        i2c_wr_en,
    output logic        i2c_rd_en,
    input  logic [15:0] i2c_rdata,
    input  logic        i2c_rdata_vld,
    input  logic        i2c_rdy
);
    import ms5803_pkg::*;

    localparam int unsigned MAX_CYC =
        (PWRUP_CYC > TIMEOUT_CYC) ? PWRUP_CYC : TIMEOUT_CYC;
    localparam int CW = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

    // A zero count is treated as a single cycle.
    localparam logic [CW-1:0] PW_LAST =
        CW'((PWRUP_CYC > 1) ? PWRUP_CYC - 1 : 0);
    localparam logic [CW-1:0] TMO_LAST =
        CW'((TIMEOUT_CYC > 1) ? TIMEOUT_CYC - 1 : 0);

    state_t          st_q, st_d;
    logic [2:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            rd_en_q, rd_en_d;
    logic            word_we;
    logic            image_bad;
    logic [15:0]     word_q [PROM_WORDS];

    always_comb begin
        image_bad = 1'b0;
        for (int k = 1; k < PROM_WORDS - 1; k++) begin
            image_bad = image_bad | bad_word(word_q[k]);
        end
    end

    always_comb begin
        st_d    = st_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        err_d   = err_q;
        rd_en_d = 1'b0;
        word_we = 1'b0;
        unique case (st_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    idx_d  = 3'd0;
                    cnt_d  = '0;
                    st_d   = ST_PWRUP;
                end
            end
            ST_PWRUP: begin
                if (cnt_q == PW_LAST) begin
                    st_d = ST_ISSUE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_ISSUE: begin
                if (i2c_rdy) begin
                    rd_en_d = 1'b1;
                    cnt_d   = '0;
                    st_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i2c_rdata_vld) begin
                    word_we = 1'b1;
                    st_d    = ST_STORE;
                end else if (cnt_q == TMO_LAST) begin
                    err_d = 1'b1;
                    st_d  = ST_ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STORE: begin
                if (idx_q == 3'(PROM_WORDS - 1)) begin
                    st_d = ST_CHECK;
                end else begin
                    idx_d = idx_q + 3'd1;
                    st_d  = ST_ISSUE;
                end
            end
            ST_CHECK: begin
                if (image_bad) begin
                    err_d = 1'b1;
                    st_d  = ST_ERR;
                end else begin
                    done_d = 1'b1;
                    st_d   = ST_DONE;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= ST_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_en_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rd_en_q <= rd_en_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PROM_WORDS; k++) begin
                word_q[k] <= 16'h0000;
            end
        end else if (word_we) begin
            word_q[idx_q] <= i2c_rdata;
        end
    end

    assign coef      = word_q[coef_idx];
    assign busy      = !((st_q == ST_IDLE) || (st_q == ST_DONE) ||
                         (st_q == ST_ERR));
    assign done      = done_q;
    assign prom_err  = err_q;
    assign i2c_rd_en = rd_en_q;
    assign i2c_wdata = 8'h00;
    assign i2c_wr_en = 1'b0;
    assign i2c_addr  = ((st_q == ST_ISSUE) || (st_q == ST_WAIT)) ?
                       PROM_BASE + {4'b0000, idx_q, 1'b0} : 8'h00;

endmodule

// File: tb/tb_ms5803_prom_loader.sv
// Directed bench for ms5803_prom_loader with a small I2C PROM controller
// model; stimulus and checks run on the falling clock edge.
module tb_ms5803_prom_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  coef_idx = 3'd0;
    logic [15:0] coef;
    logic        busy, done, prom_err;
    logic [7:0]  i2c_addr, i2c_wdata;
    logic        i2c_wr_en, i2c_rd_en;
    logic [15:0] i2c_rdata = 16'h0000;
    logic        i2c_rdata_vld = 1'b0;
    logic        i2c_rdy = 1'b1;

    int checks = 0;
    int errors = 0;

    // Controller model configuration (written by the stimulus only).
    int          lat = 4;
    int          hold = 0;
    int          bad_k = -1;
    logic [15:0] bad_v = 16'hFFFF;
    int          drop_k = -1;

    // Controller model state and monitors (written by the model only).
    int          nrd = 0;
    int          rd_while_busy = 0;
    int          dbl = 0;
    int          addr_err = 0;
    int          pend = 0;
    int          hold_cnt = 0;
    int          cur_k = 0;
    logic [7:0]  last_addr = 8'h00;
    logic        prev_rd = 1'b0;
    logic        prev_busy = 1'b0;

    int base;

    ms5803_prom_loader #(
        .PWRUP_CYC(10),
        .TIMEOUT_CYC(100),
        .PROM_BASE(8'hA0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .coef_idx(coef_idx),
        .coef(coef),
        .busy(busy),
        .done(done),
        .prom_err(prom_err),
        .i2c_addr(i2c_addr),
        .i2c_wdata(i2c_wdata),
        .i2c_wr_en(i2c_wr_en),
        .i2c_rd_en(i2c_rd_en),
        .i2c_rdata(i2c_rdata),
        .i2c_rdata_vld(i2c_rdata_vld),
        .i2c_rdy(i2c_rdy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        i2c_rdata_vld = 1'b0;
        if (i2c_rd_en) begin
            nrd++;
            if (!i2c_rdy) rd_while_busy++;
            if (prev_rd) dbl++;
            if (!(i2c_addr == 8'hA0 || i2c_addr == last_addr + 8'd2))
                addr_err++;
            last_addr = i2c_addr;
            cur_k = int'((i2c_addr - 8'hA0) >> 1);
            i2c_rdy = 1'b0;
            pend = lat;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                if (cur_k != drop_k) begin
                    i2c_rdata_vld = 1'b1;
                    i2c_rdata = (cur_k == bad_k) ? bad_v
                                : 16'h1000 + 16'(cur_k);
                end
                if (hold > 0) hold_cnt = hold;
                else i2c_rdy = 1'b1;
            end
        end else if (hold_cnt > 0) begin
            hold_cnt--;
            if (hold_cnt == 0) i2c_rdy = 1'b1;
        end else if (busy && !prev_busy && hold > 0) begin
            i2c_rdy = 1'b0;
            hold_cnt = hold;
        end
        prev_rd = i2c_rd_en;
        prev_busy = busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_bound", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_reads(input int target, input int budget);
        int n;
        n = 0;
        while ((nrd - base) < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_reads_bound", nrd - base, target);
    endtask

    task automatic read_coef(input logic [2:0] i, input string tag,
                             input logic [15:0] exp);
        coef_idx = i;
        #1;
        chk(tag, {16'd0, coef}, {16'd0, exp});
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, prom_err}, 0);
        chk("rst_rd_en", {31'd0, i2c_rd_en}, 0);
        chk("rst_addr", {24'd0, i2c_addr}, 0);
        chk("rst_wr", {23'd0, i2c_wr_en, i2c_wdata}, 0);
        read_coef(3'd7, "rst_coef7", 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: plain load, first read after the 10-cycle power-up wait
        base = nrd;
        pulse_start();
        chk("t1_busy", {31'd0, busy}, 1);
        repeat (10) @(negedge clk);
        chk("t1_no_rd_in_pwrup", nrd - base, 0);
        @(negedge clk);
        chk("t1_first_rd", {31'd0, i2c_rd_en}, 1);
        chk("t1_first_addr", {24'd0, i2c_addr}, 32'hA0);
        wait_idle(2000);
        chk("t1_done", {31'd0, done}, 1);
        chk("t1_err", {31'd0, prom_err}, 0);
        chk("t1_nrd", nrd - base, 8);
        chk("t1_addr_seq", addr_err, 0);
        read_coef(3'd5, "t1_coef5", 16'h1005);
        read_coef(3'd0, "t1_coef0", 16'h1000);
        read_coef(3'd7, "t1_coef7", 16'h1007);

        // 2: controller busy for 50 cycles before every read
        hold = 50;
        base = nrd;
        pulse_start();
        wait_idle(5000);
        chk("t2_done", {31'd0, done}, 1);
        chk("t2_nrd", nrd - base, 8);
        chk("t2_rd_while_busy", rd_while_busy, 0);
        read_coef(3'd5, "t2_coef5", 16'h1005);
        hold = 0;
        repeat (60) @(negedge clk);

        // 5: start after DONE reloads; starts during the load are ignored
        base = nrd;
        pulse_start();
        chk("t5_done_clr", {31'd0, done}, 0);
        chk("t5_busy", {31'd0, busy}, 1);
        wait_reads(3, 500);
        pulse_start();
        for (int n = 0; n < 200 && !i2c_rdata_vld; n++) begin
            @(negedge clk);
            #1;
        end
        chk("t5_vld_seen", {31'd0, i2c_rdata_vld}, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(2000);
        chk("t5_done", {31'd0, done}, 1);
        chk("t5_nrd", nrd - base, 8);
        chk("t5_addr_seq", addr_err, 0);
        read_coef(3'd5, "t5_coef5", 16'h1005);

        // 3: erased word 3 fails the plausibility check
        bad_k = 3;
        bad_v = 16'hFFFF;
        base = nrd;
        pulse_start();
        wait_idle(2000);
        chk("t3_err", {31'd0, prom_err}, 1);
        chk("t3_done", {31'd0, done}, 0);
        chk("t3_nrd", nrd - base, 8);
        read_coef(3'd3, "t3_coef3", 16'hFFFF);
        bad_k = -1;

        // 4: word 2 never answers, abort 100 cycles after its read pulse
        drop_k = 2;
        base = nrd;
        pulse_start();
        chk("t4_err_clr", {31'd0, prom_err}, 0);
        for (int n = 0; n < 500 && !(i2c_rd_en && i2c_addr == 8'hA4); n++)
            @(negedge clk);
        chk("t4_third_rd", {31'd0, i2c_rd_en}, 1);
        repeat (99) @(negedge clk);
        chk("t4_err_before", {31'd0, prom_err}, 0);
        chk("t4_busy_before", {31'd0, busy}, 1);
        @(negedge clk);
        chk("t4_err_at_100", {31'd0, prom_err}, 1);
        chk("t4_busy_after", {31'd0, busy}, 0);
        repeat (20) @(negedge clk);
        chk("t4_nrd", nrd - base, 3);
        drop_k = -1;

        // 6: asynchronous reset while waiting for a read
        lat = 8;
        base = nrd;
        pulse_start();
        wait_reads(1, 500);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", {31'd0, busy}, 0);
        chk("t6_addr", {24'd0, i2c_addr}, 0);
        chk("t6_err", {31'd0, prom_err}, 0);
        read_coef(3'd0, "t6_coef0_rst", 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        read_coef(3'd0, "t6_coef0_stray", 16'h0000);
        chk("t6_idle", {30'd0, busy, done}, 0);
        lat = 4;
        base = nrd;
        pulse_start();
        wait_idle(2000);
        chk("t6_done", {31'd0, done}, 1);
        chk("t6_nrd", nrd - base, 8);
        read_coef(3'd7, "t6_coef7", 16'h1007);
        chk("all_no_double_rd", dbl, 0);
        chk("all_rd_while_busy", rd_while_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
